// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, waits on memory_ready, hands {instr, pc} to decode.
// Optional build macro FETCH_TIMEOUT_EN adds a WAIT-state timeout fault.
module instr_fetch_unit #(
  parameter int                    width      = 16,
  parameter int                    addr_width = 4,
  parameter logic [addr_width-1:0] RESET_PC   = '0,
  parameter int                    TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [addr_width-1:0] mem_addr,
  input  logic [width-1:0]      mem_data,
  input  logic                  memory_ready,
  input  logic                  mem_error,
  input  logic                  branch_valid,
  input  logic [addr_width-1:0] branch_target,
  output logic [width-1:0]      instr,
  output logic [addr_width-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  fault
);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    FAULT  = 2'd3
  } state_t;

  // The timeout counter is 8 bits wide, so TIMEOUT must fit in it.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("instr_fetch_unit: TIMEOUT must be in 1..255");
  end

  state_t                state;
  logic [addr_width-1:0] pc;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT);
  logic [7:0] wait_count;
`endif

  assign mem_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      state       <= SETTLE;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_count  <= '0;
`endif
    end else begin
      case (state)
        // Stale memory_ready from the previous address is ignored here.
        SETTLE: begin
`ifdef FETCH_TIMEOUT_EN
          wait_count <= '0;
`endif
          if (branch_valid) begin
            pc <= branch_target;
          end else begin
            state <= WAIT;
          end
        end
        // Priority: memory error, then redirect, then data capture.
        WAIT: begin
          if (mem_error) begin
            fault <= 1'b1;
            state <= FAULT;
          end else if (branch_valid) begin
            pc    <= branch_target;
            state <= SETTLE;
          end else if (memory_ready) begin
            instr       <= mem_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= HOLD;
`ifdef FETCH_TIMEOUT_EN
          end else if (wait_count + 8'd1 == TimeoutLimit) begin
            fault <= 1'b1;
            state <= FAULT;
          end else begin
            wait_count <= wait_count + 8'd1;
`endif
          end
        end
        // A redirect here drops the word, or follows a completed transfer.
        HOLD: begin
          if (branch_valid) begin
            instr_valid <= 1'b0;
            pc          <= branch_target;
            state       <= SETTLE;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            pc          <= pc + addr_width'(1);
            state       <= SETTLE;
          end
        end
        FAULT: begin
          instr_valid <= 1'b0;
          fault       <= 1'b1;
        end
        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream stage of memory_controller; owns the program counter (PC) and drives the instruction-memory address.
- Waits for memory_ready, captures the memory word, and hands {instr, pc} to decode over a valid/ready handshake.
- Handles branch redirects from execute.
- Latches a sticky fault on an out-of-range address (memory error) and stops fetching.

Parameters:
- width, 16, instruction/data word width in bits.
- addr_width, 4, PC and memory address width; memory depth is 1 << addr_width.
- RESET_PC, 0, PC value loaded on reset.
- TIMEOUT, 15, maximum WAIT cycles before a timeout fault (used only with FETCH_TIMEOUT_EN); counter width is 8 bits.

Ports:
- clk, input, 1, single system clock; all logic on its rising edge.
- rst_n, input, 1, synchronous active-low reset.
- mem_addr, output, addr_width, address to memory_controller; equals the PC register.
- mem_data, input, width, instruction word from memory at mem_addr.
- memory_ready, input, 1, memory_controller ready flag.
- mem_error, input, 1, memory_controller out-of-range flag.
- branch_valid, input, 1, one-cycle redirect request.
- branch_target, input, addr_width, redirect PC.
- instr, output, width, captured instruction.
- instr_pc, output, addr_width, PC of instr.
- instr_valid, output, 1, instr/instr_pc valid for decode.
- instr_ready, input, 1, decode accepts when high together with instr_valid.
- fault, output, 1, sticky fault; fetching stopped.

Behaviour:
- Reset (rst_n low at a clk edge):
  - pc = RESET_PC; state = SETTLE.
  - instr = 0, instr_pc = 0, instr_valid = 0, fault = 0.
  - Timeout counter = 0.
  - Reset mid-transaction discards everything, with no partial output.
- States: SETTLE, WAIT, HOLD, FAULT. Encode in 2 bits.
- SETTLE:
  - One cycle after any pc change (reset, increment, redirect).
  - memory_ready is ignored here, because the controller needs one cycle to drop stale ready.
  - Next state: WAIT.
- WAIT:
  - If mem_error = 1: fault <= 1, state <= FAULT.
  - Else if memory_ready = 1: instr <= mem_data, instr_pc <= pc, instr_valid <= 1, state <= HOLD.
  - Else remain in WAIT.
- HOLD:
  - instr_valid = 1; instr and instr_pc stay stable until the transfer.
  - Transfer happens when instr_valid & instr_ready: instr_valid <= 0, pc <= pc + 1 (wraps modulo 2^addr_width), state <= SETTLE.
  - The next fetch is not overlapped; throughput is at most one instruction per 3 cycles.
- FAULT:
  - Absorbing state: instr_valid = 0, fault = 1, mem_addr frozen.
  - Exits only on reset.
  - branch_valid is ignored.
- Branch redirect (SETTLE, WAIT, HOLD):
  - pc <= branch_target, instr_valid <= 0, state <= SETTLE.
  - Any in-flight or held instruction is dropped.
- Simultaneous events:
  - branch_valid and a HOLD transfer in the same cycle: the transfer completes (decode took the word) and pc <= branch_target, not pc + 1.
  - branch_valid and mem_error in WAIT: the fault wins.
  - branch_valid and memory_ready in WAIT: the redirect wins and the captured word is discarded.
- mem_addr is combinational from pc; it changes only on a clock edge.
- mem_error is sampled only in WAIT; it is ignored in SETTLE and HOLD.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle without memory_ready.
  - When the counter reaches TIMEOUT and memory_ready is still 0: fault <= 1, state <= FAULT.
  - A redirect clears the counter.
- Not defined: no counter is built, and WAIT can last indefinitely.

Test Plan:
- Reset with RESET_PC=0, memory_ready held 1, instr_ready=1:
  - mem_addr sequences 0,1,2,…, one per 3 cycles.
  - instr matches mem_data at each instr_pc.
  - After pc 15 the next address is 0 (wrap).
- Backpressure: instr_ready=0 for 5 cycles while in HOLD at pc=3:
  - instr_valid stays 1; instr and instr_pc=3 stay stable; mem_addr stays 3.
  - Raising instr_ready gives one transfer, then mem_addr=4.
- Redirect: branch_valid=1, branch_target=9 during WAIT at pc=2:
  - No instr_valid for pc 2; mem_addr=9 next cycle.
  - First delivered instr_pc=9.
  - Branch coincident with a HOLD transfer: the word is delivered and the next pc is the target.
- Error: mem_error=1 during WAIT at pc=5:
  - fault=1 next cycle; instr_valid stays 0 permanently.
  - branch_valid is ignored.
  - rst_n=0 for one edge clears fault and restarts at RESET_PC.
- Settle: memory_ready=1 continuously with a word change immediately after an address change:
  - The captured instr is the word present in WAIT, not the SETTLE-cycle value.
- FETCH_TIMEOUT_EN defined, TIMEOUT=15, memory_ready=0: fault asserts after 15 WAIT cycles. Not defined: no fault after 100 cycles.
